// File: rtl/sid_bus_master.sv
// Host-side initiator for the SID CPU bus: turns single register requests into
// 6510-style phi2 bus cycles and sequences the SID reset pulse after power-up.
`timescale 1ns/1ps
module sid_bus_master #(
  parameter int CLK_DIV      = 24,
  parameter int PHI2_HIGH    = 12,
  parameter int RESET_CYCLES = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_sel,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       phi2,
  output logic       r_w_n,
  output logic [4:0] addr,
  output logic       a5,
  output logic       a8,
  output logic       cs_n,
  output logic       cs_io1_n,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i,
  output logic       sid_res
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HIGH_START = PW'(CLK_DIV - PHI2_HIGH);
  localparam logic [RW-1:0] RES_LAST   = RW'(RESET_CYCLES - 1);

  typedef enum logic {BUS_IDLE, BUS_ACTIVE} bus_state_t;

  bus_state_t    state, state_next;
  logic [PW-1:0] phase, phase_next;
  logic [RW-1:0] res_count;
  logic          pending;

  logic          cmd_write;
  logic [1:0]    cmd_sel;
  logic [4:0]    cmd_addr;
  logic [7:0]    cmd_data;

  logic          cur_write, cur_write_next;
  logic [1:0]    cur_sel, cur_sel_next;
  logic [7:0]    cur_data, cur_data_next;

  logic          wrap, launch, done, accept, phi2_next, drive;

  assign req_ready = ~pending & ~sid_res;

  // Everything below is evaluated for the phase the next edge enters, so the
  // registered bus pins line up exactly with the phase boundaries.
  always_comb begin
    wrap           = (phase == LAST_PHASE);
    phase_next     = wrap ? '0 : phase + PW'(1);
    accept         = req_valid & req_ready;
    launch         = wrap & pending;
    done           = wrap & (state == BUS_ACTIVE);
    state_next     = state;
    cur_write_next = cur_write;
    cur_sel_next   = cur_sel;
    cur_data_next  = cur_data;
    if (launch) begin
      state_next     = BUS_ACTIVE;
      cur_write_next = cmd_write;
      cur_sel_next   = cmd_sel;
      cur_data_next  = cmd_data;
    end else if (done) begin
      state_next = BUS_IDLE;
    end
    phi2_next = (phase_next >= HIGH_START);
    drive     = (state_next == BUS_ACTIVE) & phi2_next;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= BUS_IDLE;
      phase     <= '0;
      pending   <= 1'b0;
      res_count <= '0;
      sid_res   <= 1'b1;
      cmd_write <= 1'b0;
      cmd_sel   <= 2'd0;
      cmd_addr  <= 5'd0;
      cmd_data  <= 8'h00;
      cur_write <= 1'b0;
      cur_sel   <= 2'd0;
      cur_data  <= 8'h00;
      phi2      <= 1'b0;
      r_w_n     <= 1'b1;
      addr      <= 5'd0;
      a5        <= 1'b0;
      a8        <= 1'b0;
      cs_n      <= 1'b1;
      cs_io1_n  <= 1'b1;
      data_o    <= 8'h00;
      data_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      state     <= state_next;
      phase     <= phase_next;
      cur_write <= cur_write_next;
      cur_sel   <= cur_sel_next;
      cur_data  <= cur_data_next;

      // Launch and accept never coincide: req_ready is low while pending.
      if (launch) begin
        pending <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
      if (accept) begin
        cmd_write <= req_write;
        cmd_sel   <= req_sel;
        cmd_addr  <= req_addr;
        cmd_data  <= req_data;
      end

      if (sid_res && wrap) begin
        res_count <= res_count + RW'(1);
        if (res_count == RES_LAST) begin
          sid_res <= 1'b0;
        end
      end

      phi2  <= phi2_next;
      r_w_n <= ~((state_next == BUS_ACTIVE) & cur_write_next);
      if (launch) begin
        addr <= cmd_addr;
        a5   <= (cmd_sel == 2'd1);
        a8   <= (cmd_sel == 2'd2);
      end
      cs_n     <= ~(drive & (cur_sel_next != 2'd3));
      cs_io1_n <= ~(drive & (cur_sel_next == 2'd3));
      data_oe  <= drive & cur_write_next;
      if (drive) begin
        data_o <= cur_data_next;
      end

      // The completing cycle's command is still in cur_* on this edge.
      rsp_valid <= done;
      if (done) begin
        rsp_data <= cur_write ? 8'h00 : data_i;
      end
    end
  end

endmodule

// File: tb/tb_sid_bus_master.sv
// Randomized bench for sid_bus_master: a transaction model indexed by clk count
// since reset predicts every bus, handshake and response output each cycle.
`timescale 1ns/1ps
module tb_sid_bus_master;

  localparam int CLK_DIV      = 24;
  localparam int PHI2_HIGH    = 12;
  localparam int RESET_CYCLES = 16;
  localparam int RES_LEN      = CLK_DIV * RESET_CYCLES;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] data_i = 8'h00;
  logic       req_ready, rsp_valid, phi2, r_w_n, a5, a8, cs_n, cs_io1_n, data_oe, sid_res;
  logic [7:0] rsp_data, data_o;
  logic [4:0] addr;

  sid_bus_master #(.CLK_DIV(CLK_DIV), .PHI2_HIGH(PHI2_HIGH), .RESET_CYCLES(RESET_CYCLES)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .phi2(phi2), .r_w_n(r_w_n), .addr(addr), .a5(a5), .a8(a8),
    .cs_n(cs_n), .cs_io1_n(cs_io1_n), .data_o(data_o), .data_oe(data_oe),
    .data_i(data_i), .sid_res(sid_res)
  );

  always #5 clk = ~clk;

  // A request accepted at clk edge n launches at the first period boundary
  // strictly after n and completes one full period later.
  typedef struct {
    int       acc;
    int       launch;
    bit       write;
    bit [1:0] sel;
    bit [4:0] addr;
    bit [7:0] data;
  } txn_t;

  txn_t     q[$];
  int       cyc = 0;
  int       total = 0;
  int       bad = 0;
  int       accepted = 0;
  bit       last_reset = 1'b0;
  bit [4:0] hold_addr = 5'd0;
  bit [1:0] hold_sel = 2'd0;
  bit       exp_ready = 1'b0;
  bit       exp_rsp_valid = 1'b0;
  bit [7:0] exp_rsp_data = 8'h00;
  bit       active_write = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelEdge();
    txn_t t;
    last_reset = res;
    if (res) begin
      cyc = 0;
      q.delete();
      hold_addr     = 5'd0;
      hold_sel      = 2'd0;
      exp_rsp_valid = 1'b0;
      exp_rsp_data  = 8'h00;
    end else begin
      cyc++;
      exp_rsp_valid = 1'b0;
      foreach (q[i]) begin
        if (q[i].launch + CLK_DIV == cyc) begin
          exp_rsp_valid = 1'b1;
          exp_rsp_data  = q[i].write ? 8'h00 : data_i;
        end
      end
      if (req_valid && exp_ready) begin
        t.acc    = cyc;
        t.launch = (cyc / CLK_DIV + 1) * CLK_DIV;
        t.write  = req_write;
        t.sel    = req_sel;
        t.addr   = req_addr;
        t.data   = req_data;
        q.push_back(t);
        accepted++;
      end
    end
  endtask

  task automatic checkAll();
    int          act;
    int          lat;
    bit          pend, ph2, sres, drv, rwn, csn, csio, oe;
    bit [4:0]    e_addr;
    bit [1:0]    e_sel;
    bit [7:0]    e_dat;
    logic [19:0] bus_obs, bus_exp;
    while (q.size() > 0 && cyc > q[0].launch + CLK_DIV) begin
      hold_addr = q[0].addr;
      hold_sel  = q[0].sel;
      q.delete(0);
    end
    act  = -1;
    lat  = -1;
    pend = 1'b0;
    foreach (q[i]) begin
      if (q[i].launch <= cyc) begin
        lat = i;
        if (cyc < q[i].launch + CLK_DIV) act = i;
      end else begin
        pend = 1'b1;
      end
    end
    sres      = (cyc < RES_LEN);
    exp_ready = !pend && !sres;
    ph2       = (cyc % CLK_DIV) >= (CLK_DIV - PHI2_HIGH);
    e_addr    = (lat >= 0) ? q[lat].addr : hold_addr;
    e_sel     = (lat >= 0) ? q[lat].sel : hold_sel;
    drv       = (act >= 0) && ph2;
    rwn       = !((act >= 0) && q[act].write);
    csn       = !(drv && q[act].sel != 2'd3);
    csio      = !(drv && q[act].sel == 2'd3);
    oe        = drv && q[act].write;
    e_dat     = oe ? q[act].data : 8'h00;
    active_write = (act >= 0) && q[act].write;

    bus_exp = {ph2, rwn, e_addr, e_sel == 2'd1, e_sel == 2'd2, csn, csio, oe, e_dat};
    bus_obs = {phi2, r_w_n, addr, a5, a8, cs_n, cs_io1_n, data_oe, (data_oe === 1'b1) ? data_o : 8'h00};
    checkOutput("bus", 32'(bus_obs), 32'(bus_exp));
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("sid_res", 32'(sid_res), 32'(sres));
    checkOutput("rsp", 32'({rsp_valid, rsp_data}), 32'({exp_rsp_valid, exp_rsp_data}));
    if (last_reset) begin
      checkOutput("rst_data_o", 32'(data_o), 32'h0);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit w, input bit [1:0] s,
                               input bit [4:0] a, input bit [7:0] d);
    res       = r;
    req_valid = v;
    req_write = w;
    req_sel   = s;
    req_addr  = a;
    req_data  = d;
    data_i    = 8'($urandom_range(0, 255));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
  endtask

  task automatic offerRequest(input bit w, input bit [1:0] s, input bit [4:0] a, input bit [7:0] d);
    int n0;
    int guard;
    n0    = accepted;
    guard = 0;
    while (accepted == n0 && guard < 200) begin
      applyStimulus(1'b0, 1'b1, w, s, a, d);
      guard++;
    end
    checkOutput("accept", 32'(accepted - n0), 32'd1);
  endtask

  task automatic randomTraffic(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    int guard;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    idle(RES_LEN + 4);

    offerRequest(1'b1, 2'd0, 5'h18, 8'h0F);
    idle(60);
    offerRequest(1'b0, 2'd0, 5'h1B, 8'h00);
    idle(60);
    offerRequest(1'b1, 2'd1, 5'h02, 8'h33);
    idle(60);
    offerRequest(1'b1, 2'd2, 5'h03, 8'h44);
    idle(60);
    offerRequest(1'b0, 2'd3, 5'h04, 8'h00);
    idle(60);

    offerRequest(1'b1, 2'd0, 5'h10, 8'h11);
    offerRequest(1'b1, 2'd0, 5'h05, 8'h22);
    offerRequest(1'b0, 2'd2, 5'h07, 8'h00);
    idle(100);

    randomTraffic(3000);
    idle(60);

    // Abort a write in the middle of its phi2-high window with a request queued.
    offerRequest(1'b1, 2'd0, 5'h0A, 8'h5A);
    offerRequest(1'b0, 2'd1, 5'h0B, 8'h00);
    guard = 0;
    while (!(active_write && (cyc % CLK_DIV) == 15) && guard < 200) begin
      idle(1);
      guard++;
    end
    checkOutput("abort_window", 32'(active_write && (cyc % CLK_DIV) == 15), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    idle(RES_LEN + 4);

    randomTraffic(800);
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
